// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl : fetch-stage sequencer.
//   Each cycle it selects the next PC, in priority order:
//     1. a live redirect
//     2. a redirect parked during a stall
//     3. PC + 4
//   It drives the fetch unit's write enable. Redirects that arrive while the
//   pipeline is stalled are parked. Misaligned or out-of-window PCs are
//   flagged on pc_err.
//
// Ports
//   clk             : system clock, all state updates on posedge
//   reset           : synchronous, active-high
//   stall           : freeze request from the hazard unit
//   redirect_valid  : D stage resolved a taken branch/jump
//   redirect_target : target address of that redirect
//   PC              : current PC fed back from the fetch unit
//   NPC             : next PC presented to the fetch unit (combinational)
//   IFU_en          : fetch unit PC write enable (combinational)
//   pc_err          : PC misaligned or outside [BASE, BASE + 4*IM_DEPTH)
//   pend_valid      : a parked redirect is held
//   state           : 0 = RUN, 1 = HOLD, 2 = HOLD_REDIR
//   fetch_cnt       : number of cycles in which the PC advanced
// ---------------------------------------------------------------------------
module fetch_ctrl #(
  parameter logic [31:0] BASE     = 32'h0000_3000,
  parameter int unsigned IM_DEPTH = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic [31:0] PC,
  output logic [31:0] NPC,
  output logic        IFU_en,
  output logic        pc_err,
  output logic        pend_valid,
  output logic [1:0]  state,
  output logic [31:0] fetch_cnt
);

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_HOLD       = 2'd1,
    ST_HOLD_REDIR = 2'd2
  } state_t;

  // First address past the legal fetch window.
  localparam logic [31:0] LIMIT = BASE + 32'(4 * IM_DEPTH);

  state_t      state_q, state_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic        ifu_en_s;

  assign ifu_en_s = ~stall & ~reset;

  // Next-PC selection, write enable and address check.
  always_comb begin
    NPC    = PC + 32'd4;
    IFU_en = ifu_en_s;
    pc_err = 1'b0;
    if (redirect_valid) begin
      NPC = redirect_target;
    end else if (pend_valid_q) begin
      NPC = pend_target_q;
    end else begin
      NPC = PC + 32'd4;
    end
    // Informational only: does not gate IFU_en.
    if ((PC[1:0] != 2'b00) || (PC < BASE) || (PC >= LIMIT)) begin
      pc_err = 1'b1;
    end else begin
      pc_err = 1'b0;
    end
  end

  // FSM next state, parking register and fetch counter next values.
  always_comb begin
    state_d       = state_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    fetch_cnt_d   = fetch_cnt_q;

    if (!stall) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN:        state_d = redirect_valid ? ST_HOLD_REDIR : ST_HOLD;
        ST_HOLD:       state_d = redirect_valid ? ST_HOLD_REDIR : ST_HOLD;
        ST_HOLD_REDIR: state_d = ST_HOLD_REDIR;  // parked target kept even if redirect drops
        default:       state_d = ST_RUN;
      endcase
    end

    // Last redirect seen during a stall wins; any advancing edge consumes it.
    if (stall && redirect_valid) begin
      pend_valid_d  = 1'b1;
      pend_target_d = redirect_target;
    end else if (ifu_en_s) begin
      pend_valid_d  = 1'b0;
    end else begin
      pend_valid_d  = pend_valid_q;
    end

    if (ifu_en_s) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;  // wraps naturally at 2^32
    end else begin
      fetch_cnt_d = fetch_cnt_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RUN;
      pend_valid_q  <= 1'b0;
      pend_target_q <= 32'h0000_0000;
      fetch_cnt_q   <= 32'h0000_0000;
    end else begin
      state_q       <= state_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      fetch_cnt_q   <= fetch_cnt_d;
    end
  end

  assign pend_valid = pend_valid_q;
  assign state      = state_q;
  assign fetch_cnt  = fetch_cnt_q;

endmodule
